// File: rtl/baud_pkg.sv
// Shared defaults and divisor helper for the fractional baud-rate generator.
// Imported by the generator RTL and by benches that need to derive divisors.
package baud_pkg;

  localparam int unsigned DVSR_W_DEF = 12;
  localparam int unsigned FRAC_W_DEF = 4;
  localparam int unsigned OSR_DEF    = 16;

  typedef struct packed {
    logic [31:0] dvsr_int;
    logic [15:0] dvsr_frac;
  } baud_div_t;

  // Rounds clk_hz / (baud * osr) to 1/2^frac_w of a cycle; dvsr_int holds the period minus one.
  function automatic baud_div_t calc_div(input longint unsigned clk_hz,
                                         input longint unsigned baud,
                                         input int unsigned     osr,
                                         input int unsigned     frac_w);
    longint unsigned osr_l;
    longint unsigned den;
    longint unsigned total;
    baud_div_t       res;
    osr_l         = 64'(osr);
    den           = baud * osr_l;
    total         = ((clk_hz << frac_w) + (den >> 1)) / den;
    res.dvsr_int  = 32'((total >> frac_w) - 64'd1);
    res.dvsr_frac = 16'(total & ((64'd1 << frac_w) - 64'd1));
    return res;
  endfunction

endpackage

// File: rtl/baud_os_div.sv
// Oversample divider: counts period wraps into os_idx and flags the last and
// middle oversample of each bit, all registered so they align with tick.
module baud_os_div #(
  parameter int unsigned OSR = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   step,
  output logic [$clog2(OSR)-1:0] os_idx,
  output logic                   bit_tick,
  output logic                   mid_tick
);

  localparam int unsigned     IdxW    = $clog2(OSR);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(OSR - 1);
  localparam logic [IdxW-1:0] IdxMid  = IdxW'(OSR / 2 - 1);

  logic [IdxW-1:0] idx_q, idx_d;
  logic            bit_q, bit_d;
  logic            mid_q, mid_d;

  always_comb begin
    idx_d = idx_q;
    bit_d = 1'b0;
    mid_d = 1'b0;
    if (clear) begin
      idx_d = '0;
    end else if (step) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      bit_d = (idx_q == IdxLast);
      mid_d = (idx_q == IdxMid);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      bit_q <= 1'b0;
      mid_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      bit_q <= bit_d;
      mid_q <= mid_d;
    end
  end

  assign os_idx   = idx_q;
  assign bit_tick = bit_q;
  assign mid_tick = mid_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: dual-modulus period counter plus fractional
// accumulator, with divisor shadows that only change at a period boundary.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned DVSR_W = DVSR_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  parameter int unsigned OSR    = OSR_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   restart,
  input  logic [DVSR_W-1:0]      dvsr_int,
  input  logic [FRAC_W-1:0]      dvsr_frac,
  output logic                   tick,
  output logic                   bit_tick,
  output logic                   mid_tick,
  output logic [$clog2(OSR)-1:0] os_idx
);

  // One extra bit so int_sh at its maximum plus a pending carry still fits.
  localparam int unsigned CntW = DVSR_W + 1;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   limit;
  logic [DVSR_W-1:0] int_sh_q, int_sh_d;
  logic [FRAC_W-1:0] frac_sh_q, frac_sh_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              tick_q, tick_d;
  logic [FRAC_W:0]   acc_sum;
  logic              wrap;
  logic              load_sh;

  assign limit   = {1'b0, int_sh_q} + CntW'(carry_q);
  assign wrap    = enable & ~restart & (cnt_q == limit);
  assign load_sh = restart | ~enable | wrap;
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_sh_q};

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    tick_d  = 1'b0;
    if (restart) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (enable) begin
      if (wrap) begin
        cnt_d            = '0;
        {carry_d, acc_d} = acc_sum;
        tick_d           = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign int_sh_d  = load_sh ? dvsr_int  : int_sh_q;
  assign frac_sh_d = load_sh ? dvsr_frac : frac_sh_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      int_sh_q  <= '0;
      frac_sh_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      int_sh_q  <= int_sh_d;
      frac_sh_q <= frac_sh_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

  baud_os_div #(
    .OSR(OSR)
  ) u_os_div (
    .clk     (clk),
    .reset   (reset),
    .clear   (restart),
    .step    (wrap),
    .os_idx  (os_idx),
    .bit_tick(bit_tick),
    .mid_tick(mid_tick)
  );

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: closed-form tick-time model checked every cycle,
// plus directed scenarios with hand-computed tick spacings.
module tb_baud_gen_frac;
  import baud_pkg::*;

  localparam int unsigned DW = DVSR_W_DEF;
  localparam int unsigned FW = FRAC_W_DEF;
  localparam int unsigned OS = OSR_DEF;
  localparam int unsigned IW = $clog2(OS);

  logic          clk;
  logic          reset;
  logic          enable;
  logic          restart;
  logic [DW-1:0] dvsr_int;
  logic [FW-1:0] dvsr_frac;
  logic          tick;
  logic          bit_tick;
  logic          mid_tick;
  logic [IW-1:0] os_idx;

  int     checks = 0;
  int     errors = 0;
  bit     model_on = 0;
  longint cyc = 0;
  longint c0 = 0;
  longint tick_log[$];
  longint bit_log[$];
  longint mid_log[$];

  longint m_cnt = 0;
  longint m_next = 1;
  longint m_ticks = 0;
  bit     m_tick = 0;

  baud_gen_frac #(
    .DVSR_W(DW),
    .FRAC_W(FW),
    .OSR   (OS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .restart  (restart),
    .dvsr_int (dvsr_int),
    .dvsr_frac(dvsr_frac),
    .tick     (tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .os_idx   (os_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enabled-edge index (since restart) at which tick j appears with constant divisors.
  function automatic longint tick_edge(input longint j, input longint i, input longint f);
    return j * (i + 1) + (((j - 1) * f) >> FW);
  endfunction

  function automatic longint qget(input longint q[$], input int k);
    if (k >= q.size()) return -1;
    return q[k];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model step and per-cycle compare
  always @(posedge clk) begin
    bit     e_bit;
    bit     e_mid;
    longint e_os;
    cyc = cyc + 1;
    if (reset || restart) begin
      m_cnt   = 0;
      m_next  = 1;
      m_ticks = 0;
      m_tick  = 0;
    end else if (enable) begin
      m_cnt  = m_cnt + 1;
      m_tick = (m_cnt == tick_edge(m_next, longint'(dvsr_int), longint'(dvsr_frac)));
      if (m_tick) begin
        m_ticks = m_ticks + 1;
        m_next  = m_next + 1;
      end
    end else begin
      m_tick = 0;
    end
    #1;
    if (tick === 1'b1) tick_log.push_back(cyc);
    if (bit_tick === 1'b1) bit_log.push_back(cyc);
    if (mid_tick === 1'b1) mid_log.push_back(cyc);
    if (model_on && !reset) begin
      e_os  = m_ticks % OS;
      e_bit = m_tick && (e_os == 0);
      e_mid = m_tick && (e_os == OS / 2);
      checks++;
      if (tick !== m_tick || bit_tick !== e_bit || mid_tick !== e_mid ||
          os_idx !== IW'(e_os)) begin
        errors++;
        $display("FAIL model cyc=%0d got tick/bit/mid/os=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 cyc, tick, bit_tick, mid_tick, os_idx, m_tick, e_bit, e_mid, e_os);
      end
    end
  end

  task automatic clear_logs();
    tick_log.delete();
    bit_log.delete();
    mid_log.delete();
  endtask

  // Load divisors through a restart with enable low, then enable from this negedge (c0).
  task automatic start(input int i, input int f);
    @(negedge clk);
    enable    = 1'b0;
    dvsr_int  = DW'(i);
    dvsr_frac = FW'(f);
    restart   = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    clear_logs();
    c0     = cyc;
    enable = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    baud_div_t d;
    reset     = 1'b1;
    enable    = 1'b0;
    restart   = 1'b0;
    dvsr_int  = DW'(4);
    dvsr_frac = '0;
    #1;
    check("reset tick", tick, 0);
    check("reset bit_tick", bit_tick, 0);
    check("reset mid_tick", mid_tick, 0);
    check("reset os_idx", os_idx, 0);

    d = calc_div(64'd10137600, 64'd115200, 16, FW);
    check("calc_div int", d.dvsr_int, 4);
    check("calc_div frac", d.dvsr_frac, 8);
    d = calc_div(64'd50000000, 64'd115200, 16, FW);
    check("calc_div int 50M", d.dvsr_int, 26);
    check("calc_div frac 50M", d.dvsr_frac, 2);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_on = 1;

    // Integer period from reset
    clear_logs();
    c0     = cyc;
    enable = 1'b1;
    repeat (170) @(negedge clk);
    check("int first tick", qget(tick_log, 0) - c0, 5);
    check("int tick period", qget(tick_log, 1) - qget(tick_log, 0), 5);
    check("int mid_tick", qget(mid_log, 0) - c0, 40);
    check("int bit_tick first", qget(bit_log, 0) - c0, 80);
    check("int bit_tick period", qget(bit_log, 1) - qget(bit_log, 0), 80);

    // Fractional 4 + 8/16
    start(4, 8);
    repeat (200) @(negedge clk);
    check("frac t1", qget(tick_log, 0) - c0, 5);
    check("frac t2-t1", qget(tick_log, 1) - qget(tick_log, 0), 5);
    check("frac t3-t2", qget(tick_log, 2) - qget(tick_log, 1), 6);
    check("frac t4-t3", qget(tick_log, 3) - qget(tick_log, 2), 5);
    check("frac t5-t4", qget(tick_log, 4) - qget(tick_log, 3), 6);
    check("frac 16 tick span", qget(tick_log, 16) - qget(tick_log, 0), 88);
    check("frac mid_tick", qget(mid_log, 0) - c0, 43);
    check("frac bit_tick", qget(bit_log, 0) - c0, 87);

    // Divisor change mid-period: 9 -> 3 at cnt=2
    model_on = 0;
    start(9, 0);
    repeat (2) @(negedge clk);
    dvsr_int = DW'(3);
    repeat (30) @(negedge clk);
    check("chg current period", qget(tick_log, 0) - c0, 10);
    check("chg next period", qget(tick_log, 1) - qget(tick_log, 0), 4);
    check("chg period after", qget(tick_log, 2) - qget(tick_log, 1), 4);

    // Restart coincident with the second wrap
    start(4, 0);
    model_on = 1;
    repeat (9) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rst-wrap tick", tick, 0);
    check("rst-wrap os_idx", os_idx, 0);
    repeat (20) @(negedge clk);
    check("rst-wrap t1", qget(tick_log, 0) - c0, 5);
    check("rst-wrap t2", qget(tick_log, 1) - c0, 15);

    // Enable low for 7 cycles mid-period
    start(4, 8);
    repeat (12) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("hold os_idx", os_idx, 2);
    check("hold tick", tick, 0);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("hold t3", qget(tick_log, 2) - c0, 23);
    check("hold t4", qget(tick_log, 3) - c0, 28);

    // Continuous tick
    start(0, 0);
    repeat (40) @(negedge clk);
    check("cont tick count", tick_log.size(), 40);
    check("cont tick level", tick, 1);
    check("cont bit_tick", qget(bit_log, 0) - c0, 16);

    // Maximum integer divisor with a carry on top
    start(4095, 8);
    repeat (12300) @(negedge clk);
    check("max t1", qget(tick_log, 0) - c0, 4096);
    check("max t2-t1", qget(tick_log, 1) - qget(tick_log, 0), 4096);
    check("max t3-t2", qget(tick_log, 2) - qget(tick_log, 1), 4097);

    // Asynchronous reset while tick is high
    start(4, 0);
    repeat (5) @(negedge clk);
    check("pre-reset tick", tick, 1);
    check("pre-reset os_idx", os_idx, 1);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("async reset tick", tick, 0);
    check("async reset bit_tick", bit_tick, 0);
    check("async reset mid_tick", mid_tick, 0);
    check("async reset os_idx", os_idx, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    c0     = cyc;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("post-reset t1", qget(tick_log, 0) - c0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
